// File: rtl/axi_lite_bram_ctrl_if.sv
// AXI4-Lite slave-side bus bundle for the BRAM controller.
// The slave modport is the controller's view; master is the initiator's view.
interface axi_lite_bram_ctrl_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int AXI_ADDR_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi_lite_bram_ctrl.sv
// AXI4-Lite slave driving a single-port BRAM with 1-cycle read latency.
// One transaction in flight; reads and writes are arbitrated round-robin.
// Addresses with any bit set above the BRAM range complete with SLVERR and
// never touch the RAM.
module axi_lite_bram_ctrl #(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 19,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rstn,
    axi_lite_bram_ctrl_if.slave     s_axi,
    output logic                    ram_clk,
    output logic                    ram_en,
    output logic [DATA_WIDTH/8:0]   ram_we,
    output logic [ADDR_WIDTH-1:0]   ram_addr,
    output logic [DATA_WIDTH-1:0]   ram_wrdata,
    input  logic [DATA_WIDTH-1:0]   ram_rddata
);
    localparam int         STRB_W      = DATA_WIDTH / 8;
    localparam int         LSB         = $clog2(STRB_W);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_ACC  = 3'd1,
        WR_RESP = 3'd2,
        RD_ACC  = 3'd3,
        RD_CAP  = 3'd4,
        RD_RESP = 3'd5
    } state_t;

    state_t state, state_n;

    logic                  prio_wr;      // 1: write wins the next tie
    logic                  err_q;        // current transaction is out of range
    logic [STRB_W-1:0]     wstrb_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_wrdata_q;

    logic                  wr_pend;
    logic                  rd_pend;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  wr_err;
    logic                  rd_err;
    logic [ADDR_WIDTH-1:0] wr_word_addr;
    logic [ADDR_WIDTH-1:0] rd_word_addr;
    logic                  unused_sub_word;

    assign wr_pend = s_axi.awvalid && s_axi.wvalid;
    assign rd_pend = s_axi.arvalid;
    assign wr_err  = |s_axi.awaddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH];
    assign rd_err  = |s_axi.araddr[AXI_ADDR_WIDTH-1:ADDR_WIDTH];

    // Sub-word address bits are dropped: byte strobes select lanes instead.
    assign wr_word_addr    = {s_axi.awaddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
    assign rd_word_addr    = {s_axi.araddr[ADDR_WIDTH-1:LSB], {LSB{1'b0}}};
    assign unused_sub_word = ^{s_axi.awaddr[LSB-1:0], s_axi.araddr[LSB-1:0]};

    assign ram_clk     = clk;
    assign ram_addr    = ram_addr_q;
    assign ram_wrdata  = ram_wrdata_q;
    assign s_axi.rdata = rdata_q;

    // State register; reset abandons any transaction without a response.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Arbitration, next state and all handshake / RAM strobe outputs.
    always_comb begin
        state_n       = state;
        grant_wr      = 1'b0;
        grant_rd      = 1'b0;
        s_axi.awready = 1'b0;
        s_axi.wready  = 1'b0;
        s_axi.arready = 1'b0;
        s_axi.bvalid  = 1'b0;
        s_axi.bresp   = RESP_OKAY;
        s_axi.rvalid  = 1'b0;
        s_axi.rresp   = RESP_OKAY;
        ram_en        = 1'b0;
        ram_we        = '0;
        case (state)
            IDLE: begin
                if (wr_pend && (!rd_pend || prio_wr)) begin
                    grant_wr      = 1'b1;
                    s_axi.awready = 1'b1;
                    s_axi.wready  = 1'b1;
                    state_n       = WR_ACC;
                end else if (rd_pend) begin
                    grant_rd      = 1'b1;
                    s_axi.arready = 1'b1;
                    state_n       = RD_ACC;
                end
            end
            WR_ACC: begin
                ram_en  = !err_q;
                ram_we  = {1'b0, wstrb_q} & {(STRB_W + 1){!err_q}};
                state_n = WR_RESP;
            end
            WR_RESP: begin
                s_axi.bvalid = 1'b1;
                s_axi.bresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.bready) begin
                    state_n = IDLE;
                end
            end
            RD_ACC: begin
                ram_en  = !err_q;
                state_n = RD_CAP;
            end
            RD_CAP: begin
                state_n = RD_RESP;
            end
            RD_RESP: begin
                s_axi.rvalid = 1'b1;
                s_axi.rresp  = err_q ? RESP_SLVERR : RESP_OKAY;
                if (s_axi.rready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Latch the granted request, track round-robin priority, capture read data.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            prio_wr      <= 1'b1;
            err_q        <= 1'b0;
            wstrb_q      <= '0;
            rdata_q      <= '0;
            ram_addr_q   <= '0;
            ram_wrdata_q <= '0;
        end else begin
            if (grant_wr) begin
                prio_wr <= 1'b0;
                err_q   <= wr_err;
                wstrb_q <= s_axi.wstrb;
                // RAM-side address/data only move when a RAM access follows.
                if (!wr_err) begin
                    ram_addr_q   <= wr_word_addr;
                    ram_wrdata_q <= s_axi.wdata;
                end
            end
            if (grant_rd) begin
                prio_wr <= 1'b1;
                err_q   <= rd_err;
                if (!rd_err) begin
                    ram_addr_q <= rd_word_addr;
                end
            end
            if (state == RD_CAP) begin
                rdata_q <= err_q ? '0 : ram_rddata;
            end
        end
    end
endmodule

// File: tb/tb_axi_lite_bram_ctrl.sv
// Bench for axi_lite_bram_ctrl: directed AXI-Lite transactions, a behavioural
// 1-cycle-latency BRAM, and a negedge monitor that pops expected grants, RAM
// accesses and responses from queues filled when stimulus is issued.
module tb_axi_lite_bram_ctrl;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam byte        GW     = 8'h57;  // 'W'
    localparam byte        GR     = 8'h52;  // 'R'

    typedef struct {
        logic [18:0] addr;
        logic [8:0]  we;
    } ram_exp_t;

    typedef struct {
        logic [1:0]  resp;
        logic [63:0] data;
    } rsp_exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        ram_clk;
    logic        ram_en;
    logic [8:0]  ram_we;
    logic [18:0] ram_addr;
    logic [63:0] ram_wrdata;
    logic [63:0] ram_rddata = '0;

    axi_lite_bram_ctrl_if #(.DATA_WIDTH(64), .AXI_ADDR_WIDTH(32)) axi ();

    axi_lite_bram_ctrl #(
        .DATA_WIDTH(64), .ADDR_WIDTH(19), .AXI_ADDR_WIDTH(32)
    ) dut (
        .clk(clk), .rstn(rstn), .s_axi(axi), .ram_clk(ram_clk),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wrdata(ram_wrdata), .ram_rddata(ram_rddata)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int cyc     = 0;
    int gcyc    = 0;
    int lat_b   = 0;
    int lat_r   = 0;
    bit bvalid_d = 1'b0;
    bit rvalid_d = 1'b0;

    byte      grant_q[$];
    ram_exp_t ram_q[$];
    logic [1:0] b_q[$];
    rsp_exp_t r_q[$];

    logic [63:0] mem [0:65535];

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural BRAM: byte-enabled write, read-first, 1-cycle read latency.
    always @(posedge ram_clk) begin
        if (ram_en) begin
            for (int i = 0; i < 8; i++) begin
                if (ram_we[i]) mem[ram_addr[18:3]][i*8 +: 8] <= ram_wrdata[i*8 +: 8];
            end
            ram_rddata <= mem[ram_addr[18:3]];
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fail(input string name, input string what);
        n_total++;
        $display("FAIL %s: %s", name, what);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_awready"}, 64'(axi.awready), 64'd0);
        check({tag, "_wready"},  64'(axi.wready),  64'd0);
        check({tag, "_arready"}, 64'(axi.arready), 64'd0);
        check({tag, "_bvalid"},  64'(axi.bvalid),  64'd0);
        check({tag, "_bresp"},   64'(axi.bresp),   64'd0);
        check({tag, "_rvalid"},  64'(axi.rvalid),  64'd0);
        check({tag, "_rresp"},   64'(axi.rresp),   64'd0);
        check({tag, "_rdata"},   axi.rdata,        64'd0);
        check({tag, "_ram_en"},  64'(ram_en),      64'd0);
        check({tag, "_ram_we"},  64'(ram_we),      64'd0);
        check({tag, "_ram_addr"},   64'(ram_addr), 64'd0);
        check({tag, "_ram_wrdata"}, ram_wrdata,    64'd0);
    endtask

    // Monitor: every grant, RAM strobe and response is matched against the queues.
    always @(negedge clk) begin
        if (!rstn) begin
            bvalid_d = 1'b0;
            rvalid_d = 1'b0;
        end else begin
            if (axi.awready || axi.wready) begin
                check("aw_w_ready_together", 64'(axi.awready), 64'(axi.wready));
                if (grant_q.size() == 0) fail("grant", "got W, want none");
                else check("grant", 64'(GW), 64'(grant_q.pop_front()));
                gcyc = cyc;
            end
            if (axi.arready) begin
                if (grant_q.size() == 0) fail("grant", "got R, want none");
                else check("grant", 64'(GR), 64'(grant_q.pop_front()));
                gcyc = cyc;
            end
            if (ram_en) begin
                if (ram_q.size() == 0) begin
                    fail("ram_en", "got pulse, want none");
                end else begin
                    ram_exp_t e;
                    e = ram_q.pop_front();
                    check("ram_addr", 64'(ram_addr), 64'(e.addr));
                    check("ram_we", 64'(ram_we), 64'(e.we));
                    check("ram_en_latency", 64'(cyc - gcyc), 64'd1);
                end
            end else if (ram_we != 9'd0) begin
                check("ram_we_without_en", 64'(ram_we), 64'd0);
            end
            if (axi.bvalid && !bvalid_d) lat_b = cyc - gcyc;
            if (axi.rvalid && !rvalid_d) lat_r = cyc - gcyc;
            if (axi.bvalid && axi.bready) begin
                if (b_q.size() == 0) begin
                    fail("bresp", "got B response, want none");
                end else begin
                    check("bresp", 64'(axi.bresp), 64'(b_q.pop_front()));
                    check("b_latency", 64'(lat_b), 64'd2);
                end
            end
            if (axi.rvalid && axi.rready) begin
                if (r_q.size() == 0) begin
                    fail("rresp", "got R response, want none");
                end else begin
                    rsp_exp_t e;
                    e = r_q.pop_front();
                    check("rresp", 64'(axi.rresp), 64'(e.resp));
                    check("rdata", axi.rdata, e.data);
                    check("r_latency", 64'(lat_r), 64'd3);
                end
            end
            bvalid_d = axi.bvalid;
            rvalid_d = axi.rvalid;
        end
    end

    task automatic wait_grant(input bit is_wr, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_wr ? axi.awready : axi.arready) && n < 50);
        if (!(is_wr ? axi.awready : axi.arready)) fail(tag, "got no grant, want grant within 50 cycles");
        @(posedge clk); #1;
    endtask

    task automatic wait_resp(input bit is_wr, input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(is_wr ? (axi.bvalid && axi.bready) : (axi.rvalid && axi.rready)) && n < 50);
        if (!(is_wr ? (axi.bvalid && axi.bready) : (axi.rvalid && axi.rready)))
            fail(tag, "got no response, want response within 50 cycles");
        @(posedge clk); #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s,
                            input logic [1:0] er, input logic [18:0] exp_addr);
        grant_q.push_back(GW);
        b_q.push_back(er);
        if (er == OKAY) ram_q.push_back('{exp_addr, {1'b0, s}});
        axi.awaddr = a; axi.wdata = d; axi.wstrb = s;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_grant(1'b1, "write_grant");
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        wait_resp(1'b1, "write_resp");
    endtask

    task automatic do_read(input logic [31:0] a, input logic [63:0] d, input logic [1:0] er,
                           input logic [18:0] exp_addr);
        grant_q.push_back(GR);
        r_q.push_back('{er, d});
        if (er == OKAY) ram_q.push_back('{exp_addr, 9'h000});
        axi.araddr = a; axi.arvalid = 1'b1;
        wait_grant(1'b0, "read_grant");
        axi.arvalid = 1'b0;
        wait_resp(1'b0, "read_resp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, want finish before 200000 time units");
        $fatal(1, "watchdog");
    end

    initial begin
        int ng;
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = '0;
        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
        axi.wvalid = 1'b0; axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1; rstn = 1'b1;

        // AW valid in cycle 1, W valid in cycle 3: ready only in cycle 3
        grant_q.push_back(GW);
        b_q.push_back(OKAY);
        ram_q.push_back('{19'h18, 9'h0FF});
        @(posedge clk); #1; axi.awaddr = 32'h18; axi.awvalid = 1'b1;
        @(negedge clk);
        check("aw_only_c1_awready", 64'(axi.awready), 64'd0);
        check("aw_only_c1_wready",  64'(axi.wready),  64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("aw_only_c2_awready", 64'(axi.awready), 64'd0);
        @(posedge clk); #1;
        axi.wdata = 64'h0123_4567_89AB_CDEF; axi.wstrb = 8'hFF; axi.wvalid = 1'b1;
        @(negedge clk);
        check("aw_w_c3_awready", 64'(axi.awready), 64'd1);
        check("aw_w_c3_wready",  64'(axi.wready),  64'd1);
        @(posedge clk); #1; axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        wait_resp(1'b1, "late_w_resp");
        do_read(32'h18, 64'h0123_4567_89AB_CDEF, OKAY, 19'h18);

        // Full-word write and read back
        do_write(32'h10, 64'h1122_3344_5566_7788, 8'hFF, OKAY, 19'h10);
        do_read(32'h10, 64'h1122_3344_5566_7788, OKAY, 19'h10);

        // Partial strobe; read through a sub-word address
        do_write(32'h10, 64'hAAAA_AAAA_BBBB_BBBB, 8'h0F, OKAY, 19'h10);
        do_read(32'h14, 64'h1122_3344_BBBB_BBBB, OKAY, 19'h10);

        // Zero strobe: RAM strobed with no byte enables, contents unchanged
        do_write(32'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, OKAY, 19'h10);
        do_read(32'h10, 64'h1122_3344_BBBB_BBBB, OKAY, 19'h10);

        // Both classes held valid: grants alternate W,R,W,R
        grant_q.push_back(GW); grant_q.push_back(GR);
        grant_q.push_back(GW); grant_q.push_back(GR);
        ram_q.push_back('{19'h20, 9'h0FF}); ram_q.push_back('{19'h20, 9'h000});
        ram_q.push_back('{19'h20, 9'h0FF}); ram_q.push_back('{19'h20, 9'h000});
        b_q.push_back(OKAY); b_q.push_back(OKAY);
        r_q.push_back('{OKAY, 64'h1111_1111_1111_1111});
        r_q.push_back('{OKAY, 64'h2222_2222_2222_2222});
        axi.awaddr = 32'h20; axi.wdata = 64'h1111_1111_1111_1111; axi.wstrb = 8'hFF;
        axi.araddr = 32'h20;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.arvalid = 1'b1;
        ng = 0; n = 0;
        while (ng < 4 && n < 200) begin
            @(negedge clk); n++;
            if (axi.awready) begin
                ng++;
                @(posedge clk); #1; axi.wdata = 64'h2222_2222_2222_2222;
            end else if (axi.arready) begin
                ng++;
            end
        end
        if (ng < 4) fail("rr_grants", "got fewer than 4 grants, want 4 within 200 cycles");
        @(posedge clk); #1;
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
        wait_resp(1'b0, "rr_last_read");

        // bready low: B held, pending read not granted
        axi.bready = 1'b0;
        grant_q.push_back(GW);
        b_q.push_back(OKAY);
        ram_q.push_back('{19'h28, 9'h0FF});
        axi.awaddr = 32'h28; axi.wdata = 64'h5A5A_5A5A_C3C3_C3C3; axi.wstrb = 8'hFF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1;
        wait_grant(1'b1, "stall_w_grant");
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        grant_q.push_back(GR);
        ram_q.push_back('{19'h28, 9'h000});
        r_q.push_back('{OKAY, 64'h5A5A_5A5A_C3C3_C3C3});
        axi.araddr = 32'h28; axi.arvalid = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!axi.bvalid && n < 20);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            check("stall_bvalid",  64'(axi.bvalid),  64'd1);
            check("stall_bresp",   64'(axi.bresp),   64'(OKAY));
            check("stall_arready", 64'(axi.arready), 64'd0);
        end
        @(posedge clk); #1; axi.bready = 1'b1;
        wait_grant(1'b0, "stall_r_grant");
        axi.arvalid = 1'b0;
        wait_resp(1'b0, "stall_r_resp");

        // Reset asserted while in RD_CAP: everything clears immediately
        grant_q.push_back(GR);
        ram_q.push_back('{19'h18, 9'h000});
        axi.araddr = 32'h18; axi.arvalid = 1'b1;
        wait_grant(1'b0, "rst_r_grant");
        axi.arvalid = 1'b0;
        @(posedge clk); #1; rstn = 1'b0;
        #1 check_idle_outputs("mid_reset");
        @(posedge clk); @(posedge clk); #1; rstn = 1'b1;
        @(negedge clk);
        check("post_reset_bvalid", 64'(axi.bvalid), 64'd0);
        check("post_reset_rvalid", 64'(axi.rvalid), 64'd0);
        @(posedge clk); #1;
        do_read(32'h28, 64'h5A5A_5A5A_C3C3_C3C3, OKAY, 19'h28);

        // Out-of-range address: SLVERR, no RAM access, RAM-side regs hold
        do_read(32'h0008_0000, 64'd0, SLVERR, 19'h0);
        do_write(32'h0008_0000, 64'hDEAD_BEEF_DEAD_BEEF, 8'hFF, SLVERR, 19'h0);
        check("err_hold_ram_addr",   64'(ram_addr), 64'h28);
        check("err_hold_ram_wrdata", ram_wrdata,    64'd0);

        repeat (5) @(negedge clk);
        check("grant_q_drained", 64'(grant_q.size()), 64'd0);
        check("ram_q_drained",   64'(ram_q.size()),   64'd0);
        check("b_q_drained",     64'(b_q.size()),     64'd0);
        check("r_q_drained",     64'(r_q.size()),     64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
